// File: rtl/pulse_peak_finder_if.sv
// Sample-in / event-out bundle for pulse_peak_finder.
// master drives samples and readout ready; slave is the peak finder.
interface pulse_peak_finder_if #(
    parameter int DW         = 16,
    parameter int TW         = 16,
    parameter int FIFO_DEPTH = 4
);
    logic signed [DW-1:0]          in_data;
    logic                          in_valid;
    logic                          ev_ready;
    logic                          ev_valid;
    logic signed [DW-1:0]          ev_amp;
    logic [TW-1:0]                 ev_time;
    logic [7:0]                    ev_width;
    logic                          ev_pileup;
    logic                          ev_overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;

    modport master (
        output in_data, in_valid, ev_ready,
        input  ev_valid, ev_amp, ev_time, ev_width, ev_pileup, ev_overflow, fifo_level
    );

    modport slave (
        input  in_data, in_valid, ev_ready,
        output ev_valid, ev_amp, ev_time, ev_width, ev_pileup, ev_overflow, fifo_level
    );
endinterface

// File: rtl/pulse_peak_finder.sv
// Threshold pulse detector: peak amplitude/time/width per pulse, buffered in an event FIFO.
// Define PEAK_PILEUP_EN to build the valley tracker that flags pile-up.
module pulse_peak_finder #(
    parameter int DW         = 16,
    parameter int TW         = 16,
    parameter int THRESH     = 100,
    parameter int HYST       = 8,
    parameter int HOLDOFF    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    pulse_peak_finder_if.slave bus
);
    // state   | meaning
    // S_IDLE  | waiting for a sample at or above threshold
    // S_TRACK | inside a pulse, tracking peak and width
    // S_HOLD  | ignoring HOLDOFF valid samples after a pulse ends

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DW + TW + 9;
    localparam logic signed [DW-1:0] THR       = DW'(THRESH);
    localparam logic [7:0]           HOLD_LOAD = (HOLDOFF == 0) ? 8'd0 : 8'(HOLDOFF - 1);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD} state_t;

    state_t               state, state_nxt;
    logic signed [DW-1:0] sample;
    logic                 above;
    logic                 push_ev;
    logic [TW-1:0]        tcnt;
    logic signed [DW-1:0] peak_amp;
    logic [TW-1:0]        peak_time;
    logic [7:0]           width;
    logic [7:0]           hold_cnt;
    logic                 pile;

    assign sample = bus.in_data;
    assign above  = (sample >= THR);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push_ev   = 1'b0;
        if (bus.in_valid) begin
            case (state)
                S_IDLE:  if (above) state_nxt = S_TRACK;
                S_TRACK: if (!above) begin
                    push_ev   = 1'b1;
                    state_nxt = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
                end
                S_HOLD:  if (hold_cnt == 8'd0) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // hold_cnt is a down-counter; the sample seen at terminal count 0 is the last one ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt      <= '0;
            peak_amp  <= '0;
            peak_time <= '0;
            width     <= '0;
            hold_cnt  <= '0;
        end else if (bus.in_valid) begin
            tcnt <= tcnt + 1'b1;
            case (state)
                S_IDLE: if (above) begin
                    peak_amp  <= sample;
                    peak_time <= tcnt;
                    width     <= 8'd1;
                end
                S_TRACK: begin
                    if (above) begin
                        if (width != 8'hFF) width <= width + 8'd1;
                        if (sample > peak_amp) begin
                            peak_amp  <= sample;
                            peak_time <= tcnt;
                        end
                    end else begin
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                S_HOLD: if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
                default: ;
            endcase
        end
    end

`ifdef PEAK_PILEUP_EN
    localparam logic signed [DW:0] HYST_X = (DW + 1)'(HYST);

    logic signed [DW-1:0] valley;
    logic signed [DW:0]   valley_x, sample_x, valley_hyst;

    // one extra bit so valley + HYST cannot wrap near full scale
    assign valley_x    = {valley[DW-1], valley};
    assign sample_x    = {sample[DW-1], sample};
    assign valley_hyst = valley_x + HYST_X;

    always_ff @(posedge clk) begin
        if (reset) begin
            valley <= '0;
            pile   <= 1'b0;
        end else if (bus.in_valid) begin
            case (state)
                S_IDLE: if (above) begin
                    valley <= sample;
                    pile   <= 1'b0;
                end
                S_TRACK: if (above) begin
                    if ((valley < peak_amp) && (sample_x > valley_hyst)) pile <= 1'b1;
                    if (sample > peak_amp)  valley <= sample;
                    else if (sample < valley) valley <= sample;
                end
                default: ;
            endcase
        end
    end
`else
    assign pile = 1'b0;
`endif

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] head, push_data;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [LW-1:0] level;
    logic          overflow;
    logic          full, do_pop, do_push, drop;

    assign push_data = {peak_amp, peak_time, width, pile};
    assign full      = (level == LW'(FIFO_DEPTH));
    assign do_pop    = (level != '0) && bus.ev_ready;
    assign do_push   = push_ev && (!full || do_pop);
    assign drop      = push_ev && full && !do_pop;
    assign rd_next   = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // head is a register copy of mem[rd_ptr], refreshed only on pop or push into empty
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            head     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_next;
            if (drop)    overflow <= 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
            if (do_pop) begin
                if (level == LW'(1)) head <= do_push ? push_data : '0;
                else                 head <= mem[rd_next];
            end else if (do_push && (level == '0)) begin
                head <= push_data;
            end
        end
    end

    assign bus.ev_valid    = (level != '0);
    assign bus.fifo_level  = level;
    assign bus.ev_overflow = overflow;
    assign bus.ev_amp      = head[EW-1 -: DW];
    assign bus.ev_time     = head[TW+8 -: TW];
    assign bus.ev_width    = head[8:1];
    assign bus.ev_pileup   = head[0];
endmodule

// File: tb/tb_pulse_peak_finder.sv
// Scoreboard bench for pulse_peak_finder: directed pulses, expected events queued, monitor compares pops.
module tb_pulse_peak_finder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pulse_peak_finder_if #(.DW(16), .TW(16), .FIFO_DEPTH(4)) bus ();

    pulse_peak_finder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] amp;
        logic [31:0] tim;
        logic [31:0] width;
        logic [31:0] pile;
    } ev_t;

`ifdef PEAK_PILEUP_EN
    localparam int PILE_EXP = 1;
`else
    localparam int PILE_EXP = 0;
`endif

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_ev(input int amp, input int tim, input int w, input int p);
        ev_t e;
        e.amp   = amp;
        e.tim   = tim;
        e.width = w;
        e.pile  = p;
        exp_q.push_back(e);
    endtask

    // monitor: every accepted head event is compared against the oldest expectation
    always @(negedge clk) begin
        if (!reset && bus.ev_valid && bus.ev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got amp=%0d time=%0d, expected no event",
                         bus.ev_amp, bus.ev_time);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_amp",    32'(bus.ev_amp),    e.amp);
                check("ev_time",   32'(bus.ev_time),   e.tim);
                check("ev_width",  32'(bus.ev_width),  e.width);
                check("ev_pileup", 32'(bus.ev_pileup), e.pile);
            end
        end
    end

    task automatic send(input int d);
        bus.in_data  = 16'(d);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_seq(input int d[]);
        foreach (d[i]) send(d[i]);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.ev_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.fifo_level != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check({name, "_pending"}, 32'(exp_q.size()), 0);
        check({name, "_level"},   32'(bus.fifo_level), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.ev_ready = 1'b0;
        do_reset();

        check("rst_ev_valid",    32'(bus.ev_valid),    0);
        check("rst_ev_amp",      32'(bus.ev_amp),      0);
        check("rst_ev_time",     32'(bus.ev_time),     0);
        check("rst_ev_width",    32'(bus.ev_width),    0);
        check("rst_ev_pileup",   32'(bus.ev_pileup),   0);
        check("rst_ev_overflow", 32'(bus.ev_overflow), 0);
        check("rst_fifo_level",  32'(bus.fifo_level),  0);

        // single pulse and 1-cycle latency
        bus.ev_ready = 1'b1;
        expect_ev(300, 3, 3, 0);
        send_seq('{0, 50, 120, 300, 250});
        check("latency_before_end", 32'(bus.ev_valid), 0);
        send(90);
        check("latency_after_end", 32'(bus.ev_valid), 1);
        check("level_after_end", 32'(bus.fifo_level), 1);
        send(0);
        drain("single");

        // holdoff swallows the 200s; a pulse after the 4th holdoff sample is seen
        do_reset();
        expect_ev(300, 3, 3, 0);
        expect_ev(150, 10, 1, 0);
        send_seq('{0, 50, 120, 300, 250, 90, 200, 200, 0, 0, 150, 0});
        drain("holdoff");

        // overflow, then push and pop in the same cycle while full
        do_reset();
        bus.ev_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) expect_ev(200 + 10 * k, 6 * k, 1, 0);
            send(200 + 10 * k);
            send_seq('{0, 0, 0, 0, 0});
        end
        check("ovf_level",    32'(bus.fifo_level),  4);
        check("ovf_flag",     32'(bus.ev_overflow), 1);
        check("ovf_head_amp", 32'(bus.ev_amp),      200);
        expect_ev(260, 30, 1, 0);
        send(260);
        bus.ev_ready = 1'b1;
        send(0);
        bus.ev_ready = 1'b0;
        check("simul_level", 32'(bus.fifo_level), 4);
        check("simul_head_amp", 32'(bus.ev_amp), 210);
        drain("overflow");
        check("ovf_sticky", 32'(bus.ev_overflow), 1);

        // pile-up, then a re-rise exactly at valley + HYST which must not flag
        do_reset();
        check("rst2_overflow", 32'(bus.ev_overflow), 0);
        check("rst2_level",    32'(bus.fifo_level),  0);
        bus.ev_ready = 1'b1;
        expect_ev(400, 2, 5, PILE_EXP);
        expect_ev(300, 11, 3, 0);
        send_seq('{0, 200, 400, 300, 200, 330, 0, 0, 0, 0, 0, 300, 250, 258, 0});
        drain("pileup");

        // reset mid-pulse discards the event and restarts timestamps
        do_reset();
        send_seq('{0, 150, 250});
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("midrst_valid", 32'(bus.ev_valid),   0);
        check("midrst_level", 32'(bus.fifo_level), 0);
        expect_ev(120, 1, 1, 0);
        send_seq('{0, 120, 0});
        drain("midreset");

        // stalls between valid samples; width saturates and first 500 wins the tie
        do_reset();
        expect_ev(500, 2, 255, 0);
        send(0);
        send(0);
        for (int i = 0; i < 300; i++) begin
            send(500);
            bus.in_data = -16'sd1000;
            @(posedge clk);
            #1;
        end
        check("stall_no_event", 32'(bus.ev_valid), 0);
        send(0);
        drain("stall");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
